// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage miniRV pipeline: stall, flush and freeze
// controls, registered EX forwarding selects, and stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rR1,
  input  logic             id_re1,
  input  logic [4:0]       id_rR2,
  input  logic             id_re2,
  input  logic [4:0]       id_wR,
  input  logic             id_rf_we,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             pipe_freeze,
  output logic [1:0]       fwd_sel_A,
  output logic [1:0]       fwd_sel_B,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] wr;
    logic       we;
    logic       ld;
  } sb_t;

  sb_t              r_ex, r_mem, r_wb;
  logic [1:0]       r_fwd_a, r_fwd_b;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  logic       w_hit_ex, w_hit_mem, w_hit_wb;
  logic       w_luse, w_raw, w_hazard, w_bubble;
  logic [1:0] w_fwd_a_d, w_fwd_b_d;

  function automatic logic hit(input sb_t s, input logic [4:0] r, input logic re);
    return re & s.valid & s.we & (s.wr == r) & (r != 5'd0);
  endfunction

  // Priority EX > MEM > WB, judged one edge before the consumer sits in EX.
  function automatic logic [1:0] fwd_src(input sb_t ex, input sb_t mem, input sb_t wb,
                                         input logic [4:0] r, input logic re);
    if (hit(ex, r, re) && !ex.ld) return 2'b01;
    else if (hit(mem, r, re))     return 2'b10;
    else if (hit(wb, r, re))      return 2'b11;
    else                          return 2'b00;
  endfunction

  assign w_hit_ex  = hit(r_ex, id_rR1, id_re1) | hit(r_ex, id_rR2, id_re2);
  assign w_hit_mem = hit(r_mem, id_rR1, id_re1) | hit(r_mem, id_rR2, id_re2);
  assign w_hit_wb  = hit(r_wb, id_rR1, id_re1) | hit(r_wb, id_rR2, id_re2);
  assign w_luse    = id_valid & r_ex.ld & w_hit_ex;
  assign w_raw     = id_valid & (w_hit_ex | w_hit_mem | w_hit_wb);
  assign w_hazard  = FWD_EN ? w_luse : w_raw;
  assign w_bubble  = ex_branch_taken | w_hazard;

  assign w_fwd_a_d = (FWD_EN && id_valid && !w_bubble) ?
                     fwd_src(r_ex, r_mem, r_wb, id_rR1, id_re1) : 2'b00;
  assign w_fwd_b_d = (FWD_EN && id_valid && !w_bubble) ?
                     fwd_src(r_ex, r_mem, r_wb, id_rR2, id_re2) : 2'b00;

  // A taken branch outranks a stall: the redirect discards the stalled instruction.
  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    pipe_freeze = 1'b0;
    if (!cpu_rst) begin
      if (mem_busy) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        pipe_freeze = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (w_hazard) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_ex        <= '0;
      r_mem       <= '0;
      r_wb        <= '0;
      r_fwd_a     <= 2'b00;
      r_fwd_b     <= 2'b00;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!mem_busy) begin
      r_wb    <= r_mem;
      r_mem   <= r_ex;
      r_ex    <= w_bubble ? '0 : {id_valid, id_wR, id_rf_we, id_is_load};
      r_fwd_a <= w_fwd_a_d;
      r_fwd_b <= w_fwd_b_d;
      if (ex_branch_taken) r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      else if (w_hazard)   r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign fwd_sel_A = r_fwd_a;
  assign fwd_sel_B = r_fwd_b;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
